// File: rtl/reg_file.sv
// Two-read, one-write register file with registered read ports (1-cycle latency).
// Optional macro REGFILE_BYPASS_EN turns same-edge write/read collisions into write-through.
module reg_file #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_addr_a,
  input  logic [ADDR_WIDTH-1:0] read_addr_b,
  output logic [DATA_WIDTH-1:0] read_data_a,
  output logic [DATA_WIDTH-1:0] read_data_b
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] rd_a_q;
  logic [DATA_WIDTH-1:0] rd_a_d;
  logic [DATA_WIDTH-1:0] rd_b_q;
  logic [DATA_WIDTH-1:0] rd_b_d;
  logic                  wr_allowed_s;

  // Hardwired zero register: index 0 is never stored and always reads as zero.
  function automatic logic is_zero_reg(input logic [ADDR_WIDTH-1:0] addr);
    return (ZERO_REG != 0) && (addr == {ADDR_WIDTH{1'b0}});
  endfunction

  // Read-port value selection; the zero register wins over any bypass.
  function automatic logic [DATA_WIDTH-1:0] read_port(
    input logic [ADDR_WIDTH-1:0] raddr,
    input logic                  wen,
    input logic [ADDR_WIDTH-1:0] waddr,
    input logic [DATA_WIDTH-1:0] wdata,
    input logic [DATA_WIDTH-1:0] old_val
  );
    logic [DATA_WIDTH-1:0] val;
    if (is_zero_reg(raddr)) begin
      val = {DATA_WIDTH{1'b0}};
    end else begin
`ifdef REGFILE_BYPASS_EN
      if (wen && (raddr == waddr)) begin
        val = wdata;
      end else begin
        val = old_val;
      end
`else
      val = old_val;
      if (wen && (raddr == waddr)) begin
        val = old_val;
      end else begin
        val = old_val;
      end
`endif
    end
    return val;
  endfunction

  // Write-side next state.
  always_comb begin
    wr_allowed_s = write_en && !is_zero_reg(write_addr);
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wr_allowed_s) begin
      mem_d[write_addr] = write_data;
    end else begin
      mem_d[write_addr] = mem_q[write_addr];
    end
  end

  // Read-side next state for both ports, resolved independently.
  always_comb begin
    rd_a_d = read_port(read_addr_a, write_en, write_addr, write_data, mem_q[read_addr_a]);
    rd_b_d = read_port(read_addr_b, write_en, write_addr, write_data, mem_q[read_addr_b]);
  end

  // State update; reset overrides any write or read on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_WIDTH{1'b0}};
      end
      rd_a_q <= {DATA_WIDTH{1'b0}};
      rd_b_q <= {DATA_WIDTH{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      rd_a_q <= rd_a_d;
      rd_b_q <= rd_b_d;
    end
  end

  assign read_data_a = rd_a_q;
  assign read_data_b = rd_b_q;

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus pushes expected read data tagged with the
// clock edge it belongs to; an independent monitor pops and compares after that edge.
module tb_reg_file;

  logic       clk;
  logic       rst;
  logic       write_en;
  logic [1:0] write_addr;
  logic [3:0] write_data;
  logic [1:0] read_addr_a;
  logic [1:0] read_addr_b;
  logic [3:0] read_data_a;
  logic [3:0] read_data_b;

  typedef struct {
    int         edge_n;
    logic [3:0] ea;
    logic [3:0] eb;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   edge_cnt = 0;
  int   checks   = 0;
  int   errors   = 0;

`ifdef REGFILE_BYPASS_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif

  reg_file #(.DATA_WIDTH(4), .ADDR_WIDTH(2), .ZERO_REG(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .write_en    (write_en),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .read_addr_a (read_addr_a),
    .read_addr_b (read_addr_b),
    .read_data_a (read_data_a),
    .read_data_b (read_data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one edge's inputs at the falling edge; optionally push the expected outputs.
  task automatic step(input logic r, input logic we, input logic [1:0] wa,
                      input logic [3:0] wd, input logic [1:0] ra, input logic [1:0] rb,
                      input logic chk, input logic [3:0] ea, input logic [3:0] eb,
                      input string name);
    exp_t e;
    @(negedge clk);
    rst         = r;
    write_en    = we;
    write_addr  = wa;
    write_data  = wd;
    read_addr_a = ra;
    read_addr_b = rb;
    if (chk) begin
      e.edge_n = edge_cnt + 1;
      e.ea     = ea;
      e.eb     = eb;
      e.name   = name;
      sb_q.push_back(e);
    end
  endtask

  // Monitor: after each rising edge compare outputs against entries due at that edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      edge_cnt++;
      #1;
      while (sb_q.size() > 0 && sb_q[0].edge_n <= edge_cnt) begin
        e = sb_q.pop_front();
        checks++;
        if (e.edge_n != edge_cnt) begin
          errors++;
          $display("FAIL %s stale entry edge=%0d now=%0d", e.name, e.edge_n, edge_cnt);
        end else begin
          if (read_data_a !== e.ea) begin
            errors++;
            $display("FAIL %s port_a got=%h exp=%h", e.name, read_data_a, e.ea);
          end
          checks++;
          if (read_data_b !== e.eb) begin
            errors++;
            $display("FAIL %s port_b got=%h exp=%h", e.name, read_data_b, e.eb);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; write_en = 1'b0; write_addr = 2'd0; write_data = 4'h0;
    read_addr_a = 2'd0; read_addr_b = 2'd0;
    step(1'b1, 1'b0, 2'd0, 4'h0, 2'd0, 2'd0, 1'b1, 4'h0, 4'h0, "init_reset");
    // Preload, including an attempt on reg 0
    step(1'b0, 1'b1, 2'd0, 4'h1, 2'd0, 2'd0, 1'b0, 4'h0, 4'h0, "");
    step(1'b0, 1'b1, 2'd1, 4'h2, 2'd0, 2'd0, 1'b0, 4'h0, 4'h0, "");
    step(1'b0, 1'b1, 2'd2, 4'h3, 2'd0, 2'd0, 1'b0, 4'h0, 4'h0, "");
    step(1'b0, 1'b1, 2'd3, 4'h4, 2'd1, 2'd2, 1'b1, 4'h2, 4'h3, "preload_rd12");
    step(1'b0, 1'b0, 2'd0, 4'h0, 2'd3, 2'd0, 1'b1, 4'h4, 4'h0, "preload_rd30");
    // Reset clears everything, outputs zero during and after
    step(1'b1, 1'b0, 2'd0, 4'h0, 2'd1, 2'd2, 1'b1, 4'h0, 4'h0, "reset_edge");
    step(1'b0, 1'b0, 2'd0, 4'h0, 2'd1, 2'd2, 1'b1, 4'h0, 4'h0, "post_reset_12");
    step(1'b0, 1'b0, 2'd0, 4'h0, 2'd3, 2'd0, 1'b1, 4'h0, 4'h0, "post_reset_30");
    // Write / read
    step(1'b0, 1'b1, 2'd2, 4'hA, 2'd0, 2'd0, 1'b1, 4'h0, 4'h0, "wr2_rd00");
    step(1'b0, 1'b1, 2'd3, 4'h5, 2'd0, 2'd1, 1'b1, 4'h0, 4'h0, "wr3_rd01");
    step(1'b0, 1'b0, 2'd0, 4'h0, 2'd2, 2'd3, 1'b1, 4'hA, 4'h5, "rd23");
    // Zero register ignores writes, even on a colliding read
    step(1'b0, 1'b1, 2'd0, 4'hF, 2'd0, 2'd0, 1'b1, 4'h0, 4'h0, "zero_wr_collide");
    step(1'b0, 1'b0, 2'd0, 4'h0, 2'd0, 2'd0, 1'b1, 4'h0, 4'h0, "zero_rd");
    // Write-enable gating
    step(1'b0, 1'b1, 2'd1, 4'h3, 2'd2, 2'd3, 1'b1, 4'hA, 4'h5, "wr1_3");
    step(1'b0, 1'b0, 2'd1, 4'h7, 2'd1, 2'd1, 1'b1, 4'h3, 4'h3, "we0_gate");
    step(1'b0, 1'b0, 2'd0, 4'h0, 2'd1, 2'd2, 1'b1, 4'h3, 4'hA, "we0_after");
    // Same-edge collision on port A, then on port B
    step(1'b0, 1'b1, 2'd1, 4'h9, 2'd1, 2'd2, 1'b1, BYPASS ? 4'h9 : 4'h3, 4'hA, "collide_a");
    step(1'b0, 1'b0, 2'd0, 4'h0, 2'd1, 2'd1, 1'b1, 4'h9, 4'h9, "collide_a_next");
    step(1'b0, 1'b1, 2'd3, 4'h6, 2'd2, 2'd3, 1'b1, 4'hA, BYPASS ? 4'h6 : 4'h5, "collide_b");
    step(1'b0, 1'b0, 2'd0, 4'h0, 2'd3, 2'd1, 1'b1, 4'h6, 4'h9, "collide_b_next");
    // Reset priority over a same-edge write
    step(1'b1, 1'b1, 2'd2, 4'hC, 2'd2, 2'd3, 1'b1, 4'h0, 4'h0, "rst_prio_edge");
    step(1'b0, 1'b0, 2'd0, 4'h0, 2'd2, 2'd1, 1'b1, 4'h0, 4'h0, "rst_prio_after");
    step(1'b0, 1'b1, 2'd1, 4'h8, 2'd3, 2'd2, 1'b1, 4'h0, 4'h0, "wr1_8");
    step(1'b0, 1'b0, 2'd0, 4'h0, 2'd1, 2'd1, 1'b1, 4'h8, 4'h8, "rd11_same");
    step(1'b0, 1'b0, 2'd0, 4'h0, 2'd0, 2'd0, 1'b0, 4'h0, 4'h0, "");
    repeat (3) @(negedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
